act_clamp_stream: RTL

Parametrised, multi-lane streaming activation unit that applies PASS, ReLU or clamp (ReLU6-style) activations to signed quantized data. It is the successor to the single-value ReLU6 FSM. It sits between the convolution/accumulate datapath and the requantize/writeback stage. It moves one beat of LANES values per cycle under valid/ready backpressure, with per-beat runtime bounds and saturation statistics.

---
 rtl/act_pkg.sv | 21 ++
 rtl/act_clamp_lane.sv | 52 +++++
 rtl/act_clamp_stream.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// -----------------------------------------------------------------------------
// act_pkg
// Shared definitions for the streaming activation unit: the 2-bit activation
// mode type with its encodings, and the width helper for the per-beat
// clamped-lane count.
// -----------------------------------------------------------------------------
package act_pkg;

   typedef enum logic [1:0] {
      ACT_PASS  = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_CLAMP = 2'd2,
      ACT_RSVD  = 2'd3
   } act_mode_t;

   // Bits needed to hold a count in 0..lanes.
   function automatic int count_w(input int lanes);
      return $clog2(lanes + 1);
   endfunction

endpackage

// File: rtl/act_clamp_lane.sv
// -----------------------------------------------------------------------------
// act_clamp_lane
// Purely combinational activation of one signed lane.
//   x       : signed input value
//   mode    : PASS / RELU / CLAMP (reserved code behaves as PASS)
//   lo, hi  : signed lower and upper bounds
//   y       : activated value
//   clamped : high when y differs from x
// -----------------------------------------------------------------------------
module act_clamp_lane
   import act_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic signed [DATA_W-1:0] x,
   input  act_mode_t                mode,
   input  logic signed [DATA_W-1:0] lo,
   input  logic signed [DATA_W-1:0] hi,
   output logic signed [DATA_W-1:0] y,
   output logic                     clamped
);

   function automatic logic signed [DATA_W-1:0] relu_fn(
      input logic signed [DATA_W-1:0] v,
      input logic signed [DATA_W-1:0] floor_v
   );
      return (v < floor_v) ? floor_v : v;
   endfunction

   // The floor is applied before the ceiling, so an inverted window
   // (lo > hi) always resolves to hi.
   function automatic logic signed [DATA_W-1:0] clamp_fn(
      input logic signed [DATA_W-1:0] v,
      input logic signed [DATA_W-1:0] floor_v,
      input logic signed [DATA_W-1:0] ceil_v
   );
      logic signed [DATA_W-1:0] t;
      t = relu_fn(v, floor_v);
      return (t > ceil_v) ? ceil_v : t;
   endfunction

   always_comb begin
      y = x;
      case (mode)
         ACT_RELU:  y = relu_fn(x, lo);
         ACT_CLAMP: y = clamp_fn(x, lo, hi);
         default:   y = x;
      endcase
      clamped = (y != x);
   end

endmodule

// File: rtl/act_clamp_stream.sv
// -----------------------------------------------------------------------------
// act_clamp_stream
// Multi-lane streaming activation (PASS / RELU / CLAMP) with a two-stage
// valid/ready pipeline, per-beat runtime bounds and saturation statistics.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input beat handshake
//   in_data, in_last    : LANES x DATA_W signed lanes, end-of-tensor marker
//   cfg_mode/lo/hi      : activation config, sampled with each accepted beat
//   out_valid/out_ready : output beat handshake
//   out_data, out_last  : activated lanes, delayed in_last
//   done                : one-cycle pulse after an out_last beat handshakes
//   busy                : at least one beat in flight
//   cnt_clr             : synchronous clear of the statistics counters
//   beat_cnt, sat_cnt   : output beats / modified lanes since last clear
// -----------------------------------------------------------------------------
module act_clamp_stream
   import act_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANES  = 4,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*DATA_W-1:0]  in_data,
   input  logic                     in_last,
   input  logic [1:0]               cfg_mode,
   input  logic signed [DATA_W-1:0] cfg_lo,
   input  logic signed [DATA_W-1:0] cfg_hi,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*DATA_W-1:0]  out_data,
   output logic                     out_last,
   output logic                     done,
   output logic                     busy,
   input  logic                     cnt_clr,
   output logic [CNT_W-1:0]         beat_cnt,
   output logic [CNT_W-1:0]         sat_cnt
);

   localparam int CLAMP_W = count_w(LANES);

   logic                     vld_p1;
   logic [LANES*DATA_W-1:0]  data_p1;
   logic                     last_p1;
   act_mode_t                mode_p1;
   logic signed [DATA_W-1:0] lo_p1;
   logic signed [DATA_W-1:0] hi_p1;

   logic                     vld_p2;
   logic [LANES*DATA_W-1:0]  data_p2;
   logic                     last_p2;
   logic [CLAMP_W-1:0]       nclamp_p2;

   logic [LANES*DATA_W-1:0]  act_data;
   logic [LANES-1:0]         act_flag;
   logic [CLAMP_W-1:0]       act_count;

   logic s1_load;
   logic s2_load;
   logic out_hs;

   logic [CNT_W-1:0] beat_q;
   logic [CNT_W-1:0] sat_q;
   logic             done_q;

   function automatic logic [CLAMP_W-1:0] popcount(input logic [LANES-1:0] v);
      logic [CLAMP_W-1:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) begin
         n = n + CLAMP_W'(v[i]);
      end
      return n;
   endfunction

   // in_ready is forced low during reset; otherwise S1 can take a beat
   // whenever it is empty or will hand its beat to S2 this cycle.
   assign in_ready = !rst && (!vld_p1 || !vld_p2 || out_ready);
   assign s1_load  = in_valid && in_ready;
   assign s2_load  = vld_p1 && (!vld_p2 || out_ready);
   assign out_hs   = vld_p2 && out_ready;

   // ---- S1: sample input beat and its config ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (s1_load) begin
         vld_p1 <= 1'b1;
      end else if (s2_load) begin
         vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_load) begin
         data_p1 <= in_data;
         last_p1 <= in_last;
         mode_p1 <= act_mode_t'(cfg_mode);
         lo_p1   <= cfg_lo;
         hi_p1   <= cfg_hi;
      end
   end

   // ---- S1 -> S2: per-lane activation and clamp popcount ----
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      act_clamp_lane #(
         .DATA_W (DATA_W)
      ) u_lane (
         .x       (data_p1[i*DATA_W +: DATA_W]),
         .mode    (mode_p1),
         .lo      (lo_p1),
         .hi      (hi_p1),
         .y       (act_data[i*DATA_W +: DATA_W]),
         .clamped (act_flag[i])
      );
   end

   assign act_count = popcount(act_flag);

   // ---- S2: registered outputs ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2    <= 1'b0;
         data_p2   <= '0;
         last_p2   <= 1'b0;
         nclamp_p2 <= '0;
      end else begin
         if (s2_load) begin
            vld_p2    <= 1'b1;
            data_p2   <= act_data;
            last_p2   <= last_p1;
            nclamp_p2 <= act_count;
         end else if (out_hs) begin
            vld_p2 <= 1'b0;
         end
      end
   end

   // ---- Statistics and completion, driven by the output handshake ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q <= '0;
         sat_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= out_hs && last_p2;
         // A clear wins over a handshake in the same cycle.
         if (cnt_clr) begin
            beat_q <= '0;
            sat_q  <= '0;
         end else if (out_hs) begin
            beat_q <= beat_q + CNT_W'(1);
            sat_q  <= sat_q + CNT_W'(nclamp_p2);
         end
      end
   end

   assign out_valid = vld_p2;
   assign out_data  = data_p2;
   assign out_last  = last_p2;
   assign done      = done_q;
   assign busy      = vld_p1 || vld_p2;
   assign beat_cnt  = beat_q;
   assign sat_cnt   = sat_q;

endmodule
